// File: rtl/rf_sched_pkg.sv
// Shared constants, encodings and state type for the register-file write scheduler.
package rf_sched_pkg;

    // Number of register-file write ports available each cycle.
    localparam int NUM_WPORTS = 3;

    // Register index that maps onto the program counter.
    localparam logic [3:0] PC_REG = 4'd15;

    // Program-counter source select encodings.
    localparam logic [1:0] SEL_PC_INC   = 2'b00;
    localparam logic [1:0] SEL_PC_START = 2'b01;
    localparam logic [1:0] SEL_PC_DP    = 2'b11;

    // Scheduler operating state.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } rf_sched_state_t;

    // One-hot decode of a register index into a 16-bit register mask.
    function automatic logic [15:0] addr_onehot(input logic [3:0] addr);
        return 16'(1) << addr;
    endfunction

endpackage

// File: rtl/rf_port_alloc.sv
// Combinational grant logic: scans requesters in priority order, routes R15
// writes to the PC load path and packs the rest onto the free write ports.
module rf_port_alloc
    import rf_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PC_W    = 11
) (
    input  logic                             enable,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*4-1:0]             req_addr,
    input  logic [NUM_REQ*32-1:0]            req_data,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_WPORTS-1:0]            port_en,
    output logic [NUM_WPORTS-1:0][3:0]       port_addr,
    output logic [NUM_WPORTS-1:0][31:0]      port_data,
    output logic                             pc_grant,
    output logic [PC_W-1:0]                  pc_value
);

    logic [1:0]  port_cnt;
    logic [15:0] addr_taken;

    // Priority scan: index 0 first, one R15 grant, up to three distinct GPR grants.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        grant      = '0;
        port_en    = '0;
        port_addr  = '0;
        port_data  = '0;
        pc_grant   = 1'b0;
        pc_value   = '0;
        port_cnt   = 2'd0;
        addr_taken = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (enable && req_valid[i]) begin
                if (req_addr[i*4 +: 4] == PC_REG) begin
                    // Only the first R15 writer gets the PC this cycle; later ones wait.
                    if (!pc_grant) begin
                        pc_grant = 1'b1;
                        pc_value = req_data[i*32 +: PC_W];
                        grant[i] = 1'b1;
                    end
                end else if ((port_cnt < 2'(NUM_WPORTS)) && !addr_taken[req_addr[i*4 +: 4]]) begin
                    // A repeated address is deferred so the lower-priority value lands last.
                    grant[i]            = 1'b1;
                    port_en[port_cnt]   = 1'b1;
                    port_addr[port_cnt] = req_addr[i*4 +: 4];
                    port_data[port_cnt] = req_data[i*32 +: 32];
                    addr_taken          = addr_taken | addr_onehot(req_addr[i*4 +: 4]);
                    port_cnt            = port_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Write-back scheduler and PC sequencer in front of the 16-entry register file.
// Holds the BOOT/RUN/HALT state machine, the registered write-port stage and
// the pending-write mask exported to hazard logic.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PC_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*4-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  hold,
    input  logic                  pc_advance,
    input  logic                  halt,
    output logic [3:0]            w_addr1,
    output logic [3:0]            w_addr2,
    output logic [3:0]            w_addr3,
    output logic [31:0]           w_data1,
    output logic [31:0]           w_data2,
    output logic [31:0]           w_data3,
    output logic                  w_en1,
    output logic                  w_en2,
    output logic                  w_en3,
    output logic                  load_pc,
    output logic [1:0]            sel_pc,
    output logic [PC_W-1:0]       dp_pc,
    output logic [15:0]           pending_mask,
    output logic                  halted
);

    rf_sched_state_t               state_q, state_d;
    logic [NUM_WPORTS-1:0]         w_en_q, w_en_d;
    logic [NUM_WPORTS-1:0][3:0]    w_addr_q, w_addr_d;
    logic [NUM_WPORTS-1:0][31:0]   w_data_q, w_data_d;
    logic                          load_pc_q, load_pc_d;
    logic [1:0]                    sel_pc_q, sel_pc_d;
    logic [PC_W-1:0]               dp_pc_q, dp_pc_d;
    logic [15:0]                   pending_mask_q, pending_mask_d;

    logic                          alloc_en;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_WPORTS-1:0]         port_en;
    logic [NUM_WPORTS-1:0][3:0]    port_addr;
    logic [NUM_WPORTS-1:0][31:0]   port_data;
    logic                          pc_grant;
    logic [PC_W-1:0]               pc_value;

    // Grants exist only in RUN when neither a stall nor a halt request is present.
    assign alloc_en = !rst && (state_q == RUN) && !hold && !halt;

    rf_port_alloc #(
        .NUM_REQ (NUM_REQ),
        .PC_W    (PC_W)
    ) u_port_alloc (
        .enable    (alloc_en),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .grant     (grant),
        .port_en   (port_en),
        .port_addr (port_addr),
        .port_data (port_data),
        .pc_grant  (pc_grant),
        .pc_value  (pc_value)
    );

    assign req_ready = grant;

    // Next state and next output-stage contents, plus the pending mask derived from them.
    always_comb begin
        state_d   = state_q;
        w_en_d    = '0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        load_pc_d = 1'b0;
        sel_pc_d  = sel_pc_q;
        dp_pc_d   = dp_pc_q;

        case (state_q)
            BOOT: begin
                // Ask the register file to load start_pc, then start scheduling.
                load_pc_d = 1'b1;
                sel_pc_d  = SEL_PC_START;
                state_d   = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                end else if (!hold) begin
                    for (int p = 0; p < NUM_WPORTS; p++) begin
                        if (port_en[p]) begin
                            w_en_d[p]   = 1'b1;
                            w_addr_d[p] = port_addr[p];
                            w_data_d[p] = port_data[p];
                        end
                    end
                    // An R15 write overrides the sequential increment.
                    if (pc_grant) begin
                        load_pc_d = 1'b1;
                        sel_pc_d  = SEL_PC_DP;
                        dp_pc_d   = pc_value;
                    end else if (pc_advance) begin
                        load_pc_d = 1'b1;
                        sel_pc_d  = SEL_PC_INC;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        pending_mask_d = '0;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (w_en_d[p]) begin
                pending_mask_d = pending_mask_d | addr_onehot(w_addr_d[p]);
            end
        end
        if (load_pc_d) begin
            pending_mask_d = pending_mask_d | addr_onehot(PC_REG);
        end
    end

    // State and output-stage registers; reset drops any write still in flight.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q        <= BOOT;
            w_en_q         <= '0;
            w_addr_q       <= '0;
            w_data_q       <= '0;
            load_pc_q      <= 1'b0;
            sel_pc_q       <= SEL_PC_INC;
            dp_pc_q        <= '0;
            pending_mask_q <= '0;
        end else begin
            state_q        <= state_d;
            w_en_q         <= w_en_d;
            w_addr_q       <= w_addr_d;
            w_data_q       <= w_data_d;
            load_pc_q      <= load_pc_d;
            sel_pc_q       <= sel_pc_d;
            dp_pc_q        <= dp_pc_d;
            pending_mask_q <= pending_mask_d;
        end
    end

    assign w_en1        = w_en_q[0];
    assign w_en2        = w_en_q[1];
    assign w_en3        = w_en_q[2];
    assign w_addr1      = w_addr_q[0];
    assign w_addr2      = w_addr_q[1];
    assign w_addr3      = w_addr_q[2];
    assign w_data1      = w_data_q[0];
    assign w_data2      = w_data_q[1];
    assign w_data3      = w_data_q[2];
    assign load_pc      = load_pc_q;
    assign sel_pc       = sel_pc_q;
    assign dp_pc        = dp_pc_q;
    assign pending_mask = pending_mask_q;
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: a table of single-cycle vectors plus
// hand-written sequences for boot, same-address deferral, R15 contention,
// hold, halt and reset while writes are in flight.
module tb_rf_write_scheduler;

    localparam int NUM_REQ = 4;
    localparam int PC_W    = 11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*4-1:0]  req_addr;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  hold;
    logic                  pc_advance;
    logic                  halt;
    logic [3:0]            w_addr1, w_addr2, w_addr3;
    logic [31:0]           w_data1, w_data2, w_data3;
    logic                  w_en1, w_en2, w_en3;
    logic                  load_pc;
    logic [1:0]            sel_pc;
    logic [PC_W-1:0]       dp_pc;
    logic [15:0]           pending_mask;
    logic                  halted;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rf_model [16];

    rf_write_scheduler #(
        .NUM_REQ (NUM_REQ),
        .PC_W    (PC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .hold         (hold),
        .pc_advance   (pc_advance),
        .halt         (halt),
        .w_addr1      (w_addr1),
        .w_addr2      (w_addr2),
        .w_addr3      (w_addr3),
        .w_data1      (w_data1),
        .w_data2      (w_data2),
        .w_data3      (w_data3),
        .w_en1        (w_en1),
        .w_en2        (w_en2),
        .w_en3        (w_en3),
        .load_pc      (load_pc),
        .sel_pc       (sel_pc),
        .dp_pc        (dp_pc),
        .pending_mask (pending_mask),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Register-file model: commits whatever the ports carry at each edge.
    always @(posedge clk) begin
        if (w_en1) rf_model[w_addr1] <= w_data1;
        if (w_en2) rf_model[w_addr2] <= w_data2;
        if (w_en3) rf_model[w_addr3] <= w_data3;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] addr;
        logic        hold;
        logic        adv;
        logic [3:0]  exp_ready;
        logic [2:0]  exp_wen;
        logic [11:0] exp_waddr;
        logic        exp_load;
        logic [1:0]  exp_sel;
        logic [15:0] exp_mask;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int idx, input logic [3:0] addr, input logic [31:0] data);
        req_valid[idx]       = 1'b1;
        req_addr[idx*4 +: 4] = addr;
        req_data[idx*32 +: 32] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_boot_load(input string tag);
        check({tag, "_load"}, 32'(load_pc), 32'd1);
        check({tag, "_sel"},  32'(sel_pc), 32'(2'b01));
        check({tag, "_wen"},  32'({w_en3, w_en2, w_en1}), 32'd0);
    endtask

    initial begin
        //              valid    addr      hold  adv   ready    wen     waddr    load  sel    mask
        vecs[0] = '{4'b1111, 16'h4321, 1'b0, 1'b0, 4'b0111, 3'b111, 12'h321, 1'b0, 2'b00, 16'h000E};
        vecs[1] = '{4'b1000, 16'h4321, 1'b0, 1'b0, 4'b1000, 3'b001, 12'h004, 1'b0, 2'b00, 16'h0010};
        vecs[2] = '{4'b1010, 16'hF0F0, 1'b0, 1'b1, 4'b0010, 3'b000, 12'h000, 1'b1, 2'b11, 16'h8000};
        vecs[3] = '{4'b1000, 16'hF0F0, 1'b0, 1'b1, 4'b1000, 3'b000, 12'h000, 1'b1, 2'b11, 16'h8000};
        vecs[4] = '{4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 3'b000, 12'h000, 1'b1, 2'b00, 16'h8000};
        vecs[5] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 3'b000, 12'h000, 1'b0, 2'b00, 16'h0000};
        vecs[6] = '{4'b1111, 16'h977F, 1'b0, 1'b1, 4'b1011, 3'b011, 12'h097, 1'b1, 2'b11, 16'h8280};
        vecs[7] = '{4'b1111, 16'h4321, 1'b1, 1'b1, 4'b0000, 3'b000, 12'h000, 1'b0, 2'b00, 16'h0000};
        vecs[8] = '{4'b1111, 16'h0E00, 1'b0, 1'b0, 4'b0101, 3'b011, 12'h0E0, 1'b0, 2'b00, 16'h4001};
        vecs[9] = '{4'b1111, 16'hBCDE, 1'b0, 1'b1, 4'b0111, 3'b111, 12'hCDE, 1'b1, 2'b00, 16'hF000};

        for (int r = 0; r < 16; r++) rf_model[r] = '0;

        // Reset with requests already valid: nothing may be accepted.
        rst        = 1'b1;
        hold       = 1'b0;
        pc_advance = 1'b0;
        halt       = 1'b0;
        clear_reqs();
        req_valid  = 4'b1111;
        req_addr   = 16'h4321;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   32'(req_ready), 32'd0);
        check("rst_wen",     32'({w_en3, w_en2, w_en1}), 32'd0);
        check("rst_waddr",   32'({w_addr3, w_addr2, w_addr1}), 32'd0);
        check("rst_wdata1",  w_data1, 32'd0);
        check("rst_wdata2",  w_data2, 32'd0);
        check("rst_wdata3",  w_data3, 32'd0);
        check("rst_load",    32'(load_pc), 32'd0);
        check("rst_sel",     32'(sel_pc), 32'd0);
        check("rst_dp",      32'(dp_pc), 32'd0);
        check("rst_mask",    32'(pending_mask), 32'd0);
        check("rst_halted",  32'(halted), 32'd0);

        // Release reset: BOOT cycle, then the start_pc load appears.
        clear_reqs();
        rst = 1'b0;
        #2;
        check("boot_ready", 32'(req_ready), 32'd0);
        tick();
        check_boot_load("boot");
        check("boot_mask", 32'(pending_mask), 32'h8000);

        // Table-driven single-cycle vectors.
        for (int k = 0; k < NV; k++) begin
            req_valid  = vecs[k].valid;
            req_addr   = vecs[k].addr;
            hold       = vecs[k].hold;
            pc_advance = vecs[k].adv;
            for (int i = 0; i < NUM_REQ; i++)
                req_data[i*32 +: 32] = {16'hDA7A, 12'(i), vecs[k].addr[i*4 +: 4]};
            #2;
            check($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
            tick();
            check($sformatf("v%0d_wen", k), 32'({w_en3, w_en2, w_en1}), 32'(vecs[k].exp_wen));
            if (vecs[k].exp_wen[0]) check($sformatf("v%0d_waddr1", k), 32'(w_addr1), 32'(vecs[k].exp_waddr[3:0]));
            if (vecs[k].exp_wen[1]) check($sformatf("v%0d_waddr2", k), 32'(w_addr2), 32'(vecs[k].exp_waddr[7:4]));
            if (vecs[k].exp_wen[2]) check($sformatf("v%0d_waddr3", k), 32'(w_addr3), 32'(vecs[k].exp_waddr[11:8]));
            check($sformatf("v%0d_load", k), 32'(load_pc), 32'(vecs[k].exp_load));
            if (vecs[k].exp_load) check($sformatf("v%0d_sel", k), 32'(sel_pc), 32'(vecs[k].exp_sel));
            check($sformatf("v%0d_mask", k), 32'(pending_mask), 32'(vecs[k].exp_mask));
        end
        hold       = 1'b0;
        pc_advance = 1'b0;

        // Same-address deferral: req2's R5 write must land after req0's.
        clear_reqs();
        set_req(0, 4'd5, 32'h0000AAAA);
        set_req(2, 4'd5, 32'h00005555);
        #2;
        check("r5_ready_a", 32'(req_ready), 32'b0001);
        tick();
        check("r5_wen_a",   32'({w_en3, w_en2, w_en1}), 32'b001);
        check("r5_addr_a",  32'(w_addr1), 32'd5);
        check("r5_data_a",  w_data1, 32'h0000AAAA);
        req_valid[0] = 1'b0;
        #2;
        check("r5_ready_b", 32'(req_ready), 32'b0100);
        tick();
        check("r5_wen_b",   32'({w_en3, w_en2, w_en1}), 32'b001);
        check("r5_addr_b",  32'(w_addr1), 32'd5);
        check("r5_data_b",  w_data1, 32'h00005555);
        clear_reqs();
        tick();
        check("r5_final",   rf_model[5], 32'h00005555);

        // R15 contention: req1 wins the PC, pc_advance is ignored, req3 waits.
        set_req(1, 4'd15, 32'h00000123);
        set_req(3, 4'd15, 32'h00000456);
        pc_advance = 1'b1;
        #2;
        check("pc_ready_a", 32'(req_ready), 32'b0010);
        tick();
        check("pc_load_a",  32'(load_pc), 32'd1);
        check("pc_sel_a",   32'(sel_pc), 32'(2'b11));
        check("pc_dp_a",    32'(dp_pc), 32'h123);
        req_valid[1] = 1'b0;
        #2;
        check("pc_ready_b", 32'(req_ready), 32'b1000);
        tick();
        check("pc_sel_b",   32'(sel_pc), 32'(2'b11));
        check("pc_dp_b",    32'(dp_pc), 32'h456);
        clear_reqs();
        pc_advance = 1'b0;

        // Hold for three cycles with valid requests, then release.
        set_req(0, 4'd1, 32'h11111111);
        set_req(1, 4'd2, 32'h22222222);
        hold       = 1'b1;
        pc_advance = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("hold%0d_ready", c), 32'(req_ready), 32'd0);
            tick();
            check($sformatf("hold%0d_wen", c),  32'({w_en3, w_en2, w_en1}), 32'd0);
            check($sformatf("hold%0d_load", c), 32'(load_pc), 32'd0);
        end
        hold       = 1'b0;
        pc_advance = 1'b0;
        #2;
        check("unhold_ready", 32'(req_ready), 32'b0011);
        tick();
        check("unhold_wen",   32'({w_en3, w_en2, w_en1}), 32'b011);
        check("unhold_addr",  32'({w_addr2, w_addr1}), 32'h21);
        check("unhold_data2", w_data2, 32'h22222222);
        clear_reqs();

        // Halt: a write lands, then halt blocks the next grant and sticks.
        set_req(0, 4'd6, 32'h66666666);
        #2;
        check("halt_pre_ready", 32'(req_ready), 32'b0001);
        tick();
        check("halt_pre_mask",  32'(pending_mask), 32'h0040);
        clear_reqs();
        set_req(1, 4'd8, 32'h88888888);
        halt = 1'b1;
        #2;
        check("halt_ready_a", 32'(req_ready), 32'd0);
        tick();
        check("halt_halted_a", 32'(halted), 32'd1);
        check("halt_wen_a",    32'({w_en3, w_en2, w_en1}), 32'd0);
        check("halt_mask_a",   32'(pending_mask), 32'd0);
        halt = 1'b0;
        #2;
        check("halt_ready_b", 32'(req_ready), 32'd0);
        tick();
        check("halt_halted_b", 32'(halted), 32'd1);
        check("halt_wen_b",    32'({w_en3, w_en2, w_en1}), 32'd0);

        // Reset leaves HALT and BOOT replays.
        rst = 1'b1;
        tick();
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_load",   32'(load_pc), 32'd0);
        clear_reqs();
        rst = 1'b0;
        tick();
        check_boot_load("reboot1");

        // Reset while a write sits in the output stage drops it.
        set_req(0, 4'd9, 32'h99999999);
        #2;
        check("midrst_ready", 32'(req_ready), 32'b0001);
        tick();
        check("midrst_pending", 32'(pending_mask), 32'h0200);
        clear_reqs();
        rst = 1'b1;
        tick();
        check("midrst_wen",  32'({w_en3, w_en2, w_en1}), 32'd0);
        check("midrst_mask", 32'(pending_mask), 32'd0);
        check("midrst_data", w_data1, 32'd0);
        rst = 1'b0;
        tick();
        check_boot_load("reboot2");
        set_req(0, 4'd9, 32'h99999999);
        #2;
        check("reboot_ready", 32'(req_ready), 32'b0001);
        tick();
        clear_reqs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Write-back scheduler and PC sequencer in front of the 16-entry register file. Accepts register write requests from four execution-side producers over valid/ready handshakes and packs them each cycle onto the register file's three write ports. Turns writes to R15 into PC loads and drives the boot-time load of `start_pc` and per-cycle PC increments. Exports a pending-write mask for hazard logic.

## Interface
- `NUM_REQ`, 4: number of requesters. Index 0 has the highest priority.
- `PC_W`, 11: PC width, matching the register file's `dp_pc` and `pc_out`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. Synchronous and active-high, as already decided.
- `req_valid`  in  NUM_REQ  request valid per requester.
- `req_addr`  in  NUM_REQ×4  destination register per requester.
- `req_data`  in  NUM_REQ×32  write data per requester.
- `req_ready`  out  NUM_REQ  request accepted this cycle. Combinational.
- `hold`  in  1  pipeline stall. Blocks all grants and PC activity.
- `pc_advance`  in  1  request a PC increment this cycle.
- `halt`  in  1  enter HALT. HALT is left only by `rst`.
- `w_addr1..3`  out  4 each  register file write addresses. Registered.
- `w_data1..3`  out  32 each  register file write data. Registered.
- `w_en1..3`  out  1 each  register file write enables. Registered.
- `load_pc`  out  1  PC load strobe. Registered.
- `sel_pc`  out  2  PC source select. Registered.
- `dp_pc`  out  PC_W  PC load value. Registered.
- `pending_mask`  out  16  one bit per register written at the next edge. Registered.
- `halted`  out  1  high while in HALT.

## Operation
- States:
  - BOOT: `req_ready`=0. Output stage gets `load_pc`=1, `sel_pc`=01. Next state RUN.
  - RUN: normal scheduling as described below.
  - HALT: `req_ready`=0. Output stage gets all enables 0.
- Transitions:
  - `rst` forces BOOT from any state.
  - RUN with `halt`=1 goes to HALT. HALT takes priority over grants in that cycle.
- Grant rules in RUN with `hold`=0, scanning requesters from index 0 upward:
  - Address 15: granted if no earlier R15 grant this cycle. Produces `load_pc`=1, `sel_pc`=11, `dp_pc`=`req_data[PC_W-1:0]`. Consumes no write port.
  - Other address: granted if a write port is still free and no earlier grant this cycle targets the same address.
  - Granted writes fill ports in scan order: first to port 1, second to port 2, third to port 3.
  - A request that is not granted holds `req_ready`=0. The producer keeps valid, address and data stable until granted.
- PC increment: if no R15 grant this cycle and `pc_advance`=1, the output stage gets `load_pc`=1, `sel_pc`=00. Otherwise `load_pc`=0.
- `hold`=1 in RUN: `req_ready`=0. Output stage gets all write enables 0 and `load_pc`=0.
- Address uniqueness: the enabled write ports in any cycle always carry distinct addresses. The order in which the register file resolves simultaneous writes is therefore irrelevant.
- `pending_mask`: bit a is set when some output `w_en` is set with `w_addr`=a. Bit 15 is set when output `load_pc`=1.

## Timing
- Reset values: all `w_en`=0, all `w_addr`/`w_data`=0, `load_pc`=0, `sel_pc`=00, `dp_pc`=0, `pending_mask`=0, `halted`=0, `req_ready`=0.
- Boot sequence:
  - First edge with `rst`=0 in BOOT: outputs `load_pc`=1, `sel_pc`=01.
  - The register file latches `start_pc` at the following edge.
  - `req_ready` can go high from the cycle after BOOT.
- Write latency: a handshake completing in cycle N (valid and ready both high) appears on the ports in cycle N+1. The register file commits it at the end of N+1.
- Throughput: at most 3 GPR writes plus 1 PC load per cycle.
- Same-address ordering: a lower-priority write to the same address is deferred at least one cycle, so it lands last and its value survives.
- Reset mid-operation: the output stage is cleared at the reset edge, so any pending write is dropped. BOOT then replays.
- `halted` is registered and rises the edge after `halt` is sampled in RUN.

## Structure
- Package `rf_sched_pkg` holds:
  - `NUM_WPORTS`=3 and `PC_REG`=4'd15.
  - `sel_pc` encodings: `SEL_PC_INC`=2'b00, `SEL_PC_START`=2'b01, `SEL_PC_DP`=2'b11.
  - State enum `rf_sched_state_t` {BOOT, RUN, HALT}.
- Sub-module `rf_port_alloc`: purely combinational. Takes the requests and produces the grant vector, port mapping and PC grant.
- The top level keeps the FSM, output registers and `pending_mask`.

## Test plan
- Reset, then release `rst`:
  - Every output is 0 during reset.
  - First cycle after release: `load_pc`=1, `sel_pc`=01, `req_ready`=0000.
  - Next cycle: ready is granted to valid requesters.
- Requests to R1, R2, R3, R4 on requesters 0–3:
  - `req_ready`=0111.
  - Next cycle: `w_addr1/2/3`=1/2/3, `pending_mask`=0x000E.
  - R4 is granted the following cycle and appears on port 1.
- req0 writes R5=0x0000AAAA and req2 writes R5=0x00005555:
  - Only req0 is ready.
  - req2 is granted the next cycle.
  - Final R5 value is 0x00005555.
- req1 writes R15 with data 0x00000123, `pc_advance`=1, and req3 also writes R15:
  - Outputs `load_pc`=1, `sel_pc`=11, `dp_pc`=0x123.
  - `pc_advance` is ignored and req3 waits.
- `hold` high for 3 cycles with valid requests:
  - `req_ready`=0 and all enables are 0 throughout.
  - Grants resume on the first cycle after `hold` falls.
- `halt` sampled, then `rst` while writes are pending:
  - `halted`=1 and no further grants.
  - The reset edge clears the output stage.
  - BOOT's `sel_pc`=01 load is re-issued.
